// File: rtl/biquad_iir_mc_pkg.sv
// rtl/biquad_iir_mc_pkg.sv - shared constants and state encoding for the biquad filter
package biquad_iir_mc_pkg;

    localparam int W_DEF  = 25;
    localparam int F_DEF  = 15;
    localparam int N_COEF = 5;

    localparam int C_B0 = 0;
    localparam int C_B1 = 1;
    localparam int C_B2 = 2;
    localparam int C_A1 = 3;
    localparam int C_A2 = 4;

    localparam int ONE = 1 << F_DEF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAC0 = 3'd1,
        S_MAC1 = 3'd2,
        S_MAC2 = 3'd3,
        S_MAC3 = 3'd4,
        S_MAC4 = 3'd5,
        S_RND  = 3'd6
    } state_t;

endpackage

// File: rtl/biquad_iir_mc_if.sv
// rtl/biquad_iir_mc_if.sv - sample, coefficient and result signals of the biquad filter
interface biquad_iir_mc_if
    import biquad_iir_mc_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int CH_W = 1
);
    logic                   rx;
    logic signed [W-1:0]    u;
    logic [CH_W-1:0]        ch_in;
    logic                   coef_we;
    logic [2:0]             coef_addr;
    logic signed [W-1:0]    coef_data;
    logic                   hist_clr;
    logic                   clr_err;
    logic                   rx_2;
    logic signed [W-1:0]    y;
    logic [CH_W-1:0]        ch_out;
    logic                   sat;
    logic                   busy;
    logic                   err;

    modport master (
        output rx, u, ch_in, coef_we, coef_addr, coef_data, hist_clr, clr_err,
        input  rx_2, y, ch_out, sat, busy, err
    );

    modport slave (
        input  rx, u, ch_in, coef_we, coef_addr, coef_data, hist_clr, clr_err,
        output rx_2, y, ch_out, sat, busy, err
    );
endinterface

// File: rtl/biquad_rnd_sat.sv
// rtl/biquad_rnd_sat.sv - round-half-up and saturate a 2W+3 accumulator down to W bits
module biquad_rnd_sat #(
    parameter int W = 25,
    parameter int F = 15
) (
    input  logic signed [2*W+2:0] acc_i,
    output logic signed [W-1:0]   y_o,
    output logic                  sat_o
);
    localparam int AW = 2*W + 3;
    localparam logic signed [AW-1:0] HALF  = AW'(64'(1) << (F - 1));
    localparam logic signed [AW-1:0] Y_MAX = AW'((64'(1) << (W - 1)) - 64'(1));
    localparam logic signed [AW-1:0] Y_MIN = ~Y_MAX;

    logic signed [AW-1:0] r;

    assign r = (acc_i + HALF) >>> F;

    always_comb begin
        y_o   = r[W-1:0];
        sat_o = 1'b0;
        if (r > Y_MAX) begin
            y_o   = Y_MAX[W-1:0];
            sat_o = 1'b1;
        end else if (r < Y_MIN) begin
            y_o   = Y_MIN[W-1:0];
            sat_o = 1'b1;
        end
    end
endmodule

// File: rtl/biquad_iir_mc.sv
// rtl/biquad_iir_mc.sv - time-multiplexed multi-channel biquad with one shared sequential MAC
module biquad_iir_mc
    import biquad_iir_mc_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int F    = F_DEF,
    parameter int N_CH = 2,
    parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input logic            clk,
    input logic            rst,
    biquad_iir_mc_if.slave bus
);
    localparam int AW = 2*W + 3;
    localparam logic signed [W-1:0] COEF_ONE = W'(64'(1) << F);

    state_t state_q, state_d;

    logic signed [W-1:0]  coef_q [N_COEF];
    logic signed [W-1:0]  u1_q [N_CH];
    logic signed [W-1:0]  u2_q [N_CH];
    logic signed [W-1:0]  y1_q [N_CH];
    logic signed [W-1:0]  y2_q [N_CH];

    logic signed [W-1:0]  u0_q;
    logic [CH_W-1:0]      ch_q;
    logic signed [AW-1:0] acc_q;
    logic signed [W-1:0]  y_q;
    logic [CH_W-1:0]      ch_out_q;
    logic                 sat_q;
    logic                 rx_2_q;
    logic                 err_q, err_d;
    logic                 clr_pend_q;

    logic                 idle, busy, ch_ok, addr_ok, accept, coef_wr, new_err, mac_en;
    logic signed [W-1:0]  coef_op, data_op;
    logic signed [2*W-1:0] prod;
    logic signed [W-1:0]  y_rnd;
    logic                 sat_rnd;

    assign idle    = (state_q == S_IDLE);
    assign busy    = !idle;
    assign ch_ok   = (int'(bus.ch_in) < N_CH);
    assign addr_ok = (bus.coef_addr <= 3'(C_A2));
    assign accept  = idle && bus.rx && ch_ok;
    assign coef_wr = idle && bus.coef_we && addr_ok;
    assign new_err = busy ? (bus.rx || (bus.coef_we && addr_ok)) : (bus.rx && !ch_ok);
    assign err_d   = new_err || (err_q && !bus.clr_err);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_MAC0;
            S_MAC0:  state_d = S_MAC1;
            S_MAC1:  state_d = S_MAC2;
            S_MAC2:  state_d = S_MAC3;
            S_MAC3:  state_d = S_MAC4;
            S_MAC4:  state_d = S_RND;
            S_RND:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Each MAC state pairs one coefficient with one operand of the captured channel.
    always_comb begin
        coef_op = '0;
        data_op = '0;
        mac_en  = 1'b1;
        case (state_q)
            S_MAC0: begin coef_op = coef_q[C_B0]; data_op = u0_q;       end
            S_MAC1: begin coef_op = coef_q[C_B1]; data_op = u1_q[ch_q]; end
            S_MAC2: begin coef_op = coef_q[C_B2]; data_op = u2_q[ch_q]; end
            S_MAC3: begin coef_op = coef_q[C_A1]; data_op = y1_q[ch_q]; end
            S_MAC4: begin coef_op = coef_q[C_A2]; data_op = y2_q[ch_q]; end
            default: mac_en = 1'b0;
        endcase
    end

    assign prod = (2*W)'(coef_op) * (2*W)'(data_op);

    biquad_rnd_sat #(.W(W), .F(F)) u_rnd_sat (
        .acc_i (acc_q),
        .y_o   (y_rnd),
        .sat_o (sat_rnd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            u0_q       <= '0;
            ch_q       <= '0;
            acc_q      <= '0;
            y_q        <= '0;
            ch_out_q   <= '0;
            sat_q      <= 1'b0;
            rx_2_q     <= 1'b0;
            err_q      <= 1'b0;
            clr_pend_q <= 1'b0;
            for (int k = 0; k < N_COEF; k++) begin
                coef_q[k] <= (k == C_B0) ? COEF_ONE : '0;
            end
            for (int i = 0; i < N_CH; i++) begin
                u1_q[i] <= '0;
                u2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else begin
            rx_2_q <= (state_q == S_RND);
            err_q  <= err_d;

            if (accept) begin
                u0_q  <= bus.u;
                ch_q  <= bus.ch_in;
                acc_q <= '0;
            end else if (mac_en) begin
                acc_q <= acc_q + AW'(prod);
            end

            if (coef_wr) begin
                coef_q[bus.coef_addr] <= bus.coef_data;
            end

            if (state_q == S_RND) begin
                y_q         <= y_rnd;
                sat_q       <= sat_rnd;
                ch_out_q    <= ch_q;
                u2_q[ch_q]  <= u1_q[ch_q];
                u1_q[ch_q]  <= u0_q;
                y2_q[ch_q]  <= y1_q[ch_q];
                y1_q[ch_q]  <= y_rnd;
            end

            // A clear requested mid-computation waits for IDLE so the result lands first.
            if (idle && (bus.hist_clr || clr_pend_q)) begin
                clr_pend_q <= 1'b0;
                for (int i = 0; i < N_CH; i++) begin
                    u1_q[i] <= '0;
                    u2_q[i] <= '0;
                    y1_q[i] <= '0;
                    y2_q[i] <= '0;
                end
            end else if (busy && bus.hist_clr) begin
                clr_pend_q <= 1'b1;
            end
        end
    end

    assign bus.rx_2   = rx_2_q;
    assign bus.y      = y_q;
    assign bus.ch_out = ch_out_q;
    assign bus.sat    = sat_q;
    assign bus.busy   = busy;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_biquad_iir_mc.sv
// tb/tb_biquad_iir_mc.sv - directed and randomized bench for biquad_iir_mc against a reference model
module tb_biquad_iir_mc;
    import biquad_iir_mc_pkg::*;

    localparam int W    = 25;
    localparam int F    = 15;
    localparam int N_CH = 2;
    localparam int CH_W = 1;
    localparam longint Y_MAX = 16777215;
    localparam longint Y_MIN = -16777216;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    longint coef_m [5];
    longint u1_m [N_CH];
    longint u2_m [N_CH];
    longint y1_m [N_CH];
    longint y2_m [N_CH];

    biquad_iir_mc_if #(.W(W), .CH_W(CH_W)) bus ();

    biquad_iir_mc #(.W(W), .F(F), .N_CH(N_CH), .CH_W(CH_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_clear_hist();
        for (int i = 0; i < N_CH; i++) begin
            u1_m[i] = 0;
            u2_m[i] = 0;
            y1_m[i] = 0;
            y2_m[i] = 0;
        end
    endfunction

    function automatic void model_reset();
        coef_m[0] = ONE;
        for (int k = 1; k < 5; k++) coef_m[k] = 0;
        model_clear_hist();
    endfunction

    // Exact sum, then floor((sum + one half) / one), then clamp; history advances.
    function automatic void model_eval(input int ch, input longint u0, output longint ye, output logic se);
        longint s, q;
        s = coef_m[0]*u0 + coef_m[1]*u1_m[ch] + coef_m[2]*u2_m[ch]
          + coef_m[3]*y1_m[ch] + coef_m[4]*y2_m[ch] + longint'(ONE / 2);
        q = s / longint'(ONE);
        if ((s % longint'(ONE)) != 0 && s < 0) q = q - 1;
        se = 1'b0;
        ye = q;
        if (q > Y_MAX) begin ye = Y_MAX; se = 1'b1; end
        if (q < Y_MIN) begin ye = Y_MIN; se = 1'b1; end
        u2_m[ch] = u1_m[ch];
        u1_m[ch] = u0;
        y2_m[ch] = y1_m[ch];
        y1_m[ch] = ye;
    endfunction

    task automatic write_coef(input int addr, input longint val);
        @(posedge clk); #1;
        bus.coef_we   = 1'b1;
        bus.coef_addr = 3'(addr);
        bus.coef_data = W'(val);
        @(posedge clk); #1;
        bus.coef_we   = 1'b0;
        if (addr < 5) coef_m[addr] = val;
    endtask

    task automatic clear_hist();
        @(posedge clk); #1;
        bus.hist_clr = 1'b1;
        @(posedge clk); #1;
        bus.hist_clr = 1'b0;
        model_clear_hist();
    endtask

    task automatic run_sample(input string tag, input int ch, input longint uval, output longint yo);
        longint ye;
        logic   se;
        int     lat;
        int     busy_n;
        model_eval(ch, uval, ye, se);
        @(posedge clk); #1;
        bus.rx    = 1'b1;
        bus.u     = W'(uval);
        bus.ch_in = CH_W'(ch);
        @(posedge clk); #1;
        bus.rx = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (lat < 20) begin
            @(negedge clk);
            if (bus.rx_2 === 1'b1) break;
            if (bus.busy === 1'b1) busy_n++;
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'sd7);
        check({tag, ".y"}, 64'(bus.y), ye);
        check({tag, ".ch"}, 64'(bus.ch_out), 64'(ch));
        check({tag, ".sat"}, 64'(bus.sat), 64'(se));
        check({tag, ".busy_n"}, 64'(busy_n), 64'sd6);
        check({tag, ".busy7"}, 64'(bus.busy), 64'sd0);
        yo = bus.y;
        @(negedge clk);
        check({tag, ".pulse"}, 64'(bus.rx_2), 64'sd0);
    endtask

    initial begin
        longint yo;
        int     n_pulse;
        int     at_c;
        longint y_seen;
        longint ye;
        logic   se;

        n_assert      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.rx        = 1'b0;
        bus.u         = '0;
        bus.ch_in     = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.hist_clr  = 1'b0;
        bus.clr_err   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst.y", 64'(bus.y), 64'sd0);
        check("rst.ch", 64'(bus.ch_out), 64'sd0);
        check("rst.rx_2", 64'(bus.rx_2), 64'sd0);
        check("rst.sat", 64'(bus.sat), 64'sd0);
        check("rst.busy", 64'(bus.busy), 64'sd0);
        check("rst.err", 64'(bus.err), 64'sd0);

        run_sample("pass", 0, 1000, yo);
        check("pass.y1000", yo, 64'sd1000);

        write_coef(0, 16384);
        write_coef(3, 16384);
        clear_hist();
        run_sample("imp0", 0, 32768, yo);
        check("imp0.c", yo, 64'sd16384);
        run_sample("imp1", 0, 0, yo);
        check("imp1.c", yo, 64'sd8192);
        run_sample("imp2", 0, 0, yo);
        check("imp2.c", yo, 64'sd4096);

        clear_hist();
        run_sample("iso0", 0, 32768, yo);
        check("iso0.c", yo, 64'sd16384);
        run_sample("iso1", 1, 0, yo);
        check("iso1.c", yo, 64'sd0);
        run_sample("iso2", 0, 0, yo);
        check("iso2.c", yo, 64'sd8192);
        run_sample("iso3", 1, 0, yo);
        check("iso3.c", yo, 64'sd0);
        run_sample("iso4", 0, 0, yo);
        check("iso4.c", yo, 64'sd4096);
        run_sample("iso5", 1, 0, yo);
        check("iso5.c", yo, 64'sd0);

        write_coef(3, 0);
        write_coef(0, 65536);
        run_sample("satp", 0, 16777215, yo);
        check("satp.c", yo, 64'sd16777215);
        check("satp.flag", 64'(bus.sat), 64'sd1);
        run_sample("satn", 1, -16777216, yo);
        check("satn.c", yo, -64'sd16777216);
        check("satn.flag", 64'(bus.sat), 64'sd1);

        write_coef(0, 1);
        run_sample("rnd_p", 0, 16384, yo);
        check("rnd_p.c", yo, 64'sd1);
        run_sample("rnd_h", 0, -16384, yo);
        check("rnd_h.c", yo, 64'sd0);
        run_sample("rnd_n", 0, -16385, yo);
        check("rnd_n.c", yo, -64'sd1);

        for (int k = 0; k < 5; k++) write_coef(k, longint'($urandom_range(0, 65535)) - 64'sd32768);
        write_coef(6, 123);
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 7) == 0) clear_hist();
            run_sample($sformatf("rand%0d", n), int'($urandom_range(0, N_CH - 1)),
                       longint'($urandom_range(0, 33554431)) - 64'sd16777216, yo);
        end

        for (int k = 0; k < 5; k++) write_coef(k, (k == 0) ? longint'(ONE) : 64'sd0);
        model_eval(0, 500, ye, se);
        @(posedge clk); #1;
        bus.rx = 1'b1; bus.u = W'(500); bus.ch_in = '0;
        @(posedge clk); #1;
        bus.rx = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.rx = 1'b1; bus.u = W'(999);
        @(posedge clk); #1;
        bus.rx = 1'b0;
        bus.coef_we = 1'b1; bus.coef_addr = 3'd0; bus.coef_data = W'(7);
        @(posedge clk); #1;
        bus.coef_we = 1'b0;
        n_pulse = 0;
        at_c    = 0;
        y_seen  = 0;
        for (int c = 5; c < 20; c++) begin
            @(negedge clk);
            if (bus.rx_2 === 1'b1) begin
                n_pulse++;
                at_c   = c;
                y_seen = bus.y;
            end
        end
        check("drop.pulses", 64'(n_pulse), 64'sd1);
        check("drop.cycle", 64'(at_c), 64'sd7);
        check("drop.y", y_seen, ye);
        check("drop.err", 64'(bus.err), 64'sd1);
        run_sample("drop.coef", 0, 1234, yo);
        check("drop.coef.c", yo, 64'sd1234);
        @(posedge clk); #1;
        bus.clr_err = 1'b1;
        @(posedge clk); #1;
        bus.clr_err = 1'b0;
        @(negedge clk);
        check("clr_err", 64'(bus.err), 64'sd0);

        @(posedge clk); #1;
        bus.rx = 1'b1; bus.u = W'(777); bus.ch_in = '0;
        @(posedge clk); #1;
        bus.rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        n_pulse = 0;
        for (int c = 5; c < 16; c++) begin
            @(negedge clk);
            if (bus.rx_2 === 1'b1) n_pulse++;
        end
        check("rst_mid.pulses", 64'(n_pulse), 64'sd0);
        check("rst_mid.y", 64'(bus.y), 64'sd0);
        check("rst_mid.busy", 64'(bus.busy), 64'sd0);
        check("rst_mid.err", 64'(bus.err), 64'sd0);
        run_sample("rst.pass", 0, 4321, yo);
        check("rst.pass.c", yo, 64'sd4321);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/biquad_iir_mc.md
Name: biquad_iir_mc

Overview:
- Parametrised, multi-channel, time-multiplexed second-order IIR (biquad) filter.
- Successor to the fixed 200 Hz high-pass section: coefficients are runtime-writable, so one block covers low-pass, high-pass and band-pass.
- Per-channel history is kept in register banks, and the output is rounded and saturated.
- Sits between the sample-strobe source (rx) and the downstream register/DAC path (rx_2, y). One shared sequential MAC serves all channels.

Parameters:
- W, 25, sample and coefficient width (signed two's complement).
- F, 15, fractional bits of the coefficients (Q(W-F).F); 1.0 = 2^F.
- N_CH, 2, number of channels (>=1).
- CH_W, clog2(N_CH) (min 1), channel index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  sample strobe; u and ch_in are valid while high.
- u  in  W  input sample, signed.
- ch_in  in  CH_W  channel of u.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  3  coefficient index 0..4.
- coef_data  in  W  coefficient value, signed.
- hist_clr  in  1  clears history of all channels.
- clr_err  in  1  clears err.
- rx_2  out  1  one-cycle result-valid pulse.
- y  out  W  filtered sample, signed; held until the next rx_2.
- ch_out  out  CH_W  channel of y.
- sat  out  1  y of this result was saturated; updated with rx_2.
- busy  out  1  computation in progress.
- err  out  1  sticky: rx or coef_we dropped while busy.

Behaviour:
- Equation, with signs folded into the coefficients: y = c0*u0 + c1*u1 + c2*u2 + c3*y1 + c4*y2.
  - u1, u2 are the previous inputs and y1, y2 the previous outputs, of channel ch.
- Reset (rst=1 at an edge):
  - state=IDLE; all history=0; c0=2^F, c1..c4=0 (pass-through).
  - y=0, ch_out=0, rx_2=0, sat=0, busy=0, err=0.
  - Reset mid-computation aborts it; no rx_2 is produced.
- FSM states: IDLE -> MAC0..MAC4 -> RND -> IDLE.
- Cycle numbering: rx=1 in IDLE in cycle 0.
  - Cycle 0: capture u, ch; clear the accumulator.
  - Cycles 1-5: MACk adds coef[k]*operand[k]. Operands are u0, u1[ch], u2[ch], y1[ch], y2[ch].
  - Cycle 6 (RND):
    - r = (acc + 2^(F-1)) >>> F, arithmetic shift (round half toward +inf).
    - Saturate r to [-2^(W-1), 2^(W-1)-1].
    - Register y, ch_out, sat.
    - Shift history: u2=u1, u1=u0, y2=y1, y1=y_sat (the saturated value).
  - Cycle 7: rx_2=1 for exactly one cycle; state=IDLE. A new rx is accepted in this same cycle.
  - Throughput: 1 sample per 7 cycles. busy=1 in cycles 1-6.
- Accumulator: signed, 2W+3 bits. Products are full 2W-bit; no intermediate truncation.
- rx while busy: sample dropped, err<=1; the computation in progress is unaffected.
- coef_we:
  - Applied in IDLE.
  - While busy: dropped, err<=1.
  - coef_addr 5..7: ignored, no error.
- rx and coef_we in the same IDLE cycle: the coefficient is written first; the sample then uses the new value.
- hist_clr:
  - In IDLE: zeroes all channels' history next edge.
  - While busy: deferred, applied in the cycle the FSM returns to IDLE, before any rx accepted that cycle is processed. The current result still updates history first; the clear then overrides it.
- ch_in >= N_CH: sample dropped, err<=1.
- clr_err and a new error in the same cycle: err stays 1.
- Channels are fully independent; only the coefficients are shared.

Decomposition:
- Shared package: W/F defaults, the coefficient index constants C_B0..C_A2 (0..4), the state encoding, and the ONE = 2^F constant.
- One natural sub-module, biquad_rnd_sat: combinational rounding and saturation from the 2W+3 accumulator to W bits plus a sat flag. Reusable by the other filter sections.
- The FSM, MAC, coefficient bank and history banks stay in the top module.

Test Plan:
- Pass-through after reset: rx with u=1000, ch=0 in cycle 0 -> rx_2 in cycle 7, y=1000, ch_out=0, sat=0; busy high cycles 1-6 only.
- One-pole impulse: c0=16384, c3=16384, others 0; ch0 inputs 32768, 0, 0 -> y = 16384, 8192, 4096.
- Channel isolation: repeat the impulse test with ch1 samples (all 0) interleaved -> ch1 y=0 every time; ch0 sequence still 16384, 8192, 4096.
- Saturation: c0=65536 (2.0), u=16777215 -> y=16777215, sat=1. u=-16777216 -> y=-16777216, sat=1.
- Rounding: c0=1, u=16384 -> y=1; u=-16384 -> y=0; u=-16385 -> y=-1.
- Drop, error and reset: rx again in cycle 3 -> one rx_2 only, err=1. coef_we in cycle 4 -> coefficient unchanged. clr_err -> err=0. rst in cycle 4 -> no rx_2, y=0, and the next pass-through sample returns u unchanged.
